// File: rtl/mem_port_arbiter_rv.sv
// mem_port_arbiter_rv: shares one ack-handshaked memory port between fetch (I) and data (D) requesters.
// Define MEM_ARB_TIMEOUT_EN to enable the ack-timeout watchdog that reports owBusErr.
module mem_port_arbiter_rv #(
    parameter int MAX_DATA_BURST = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwIReq,
    input  logic [31:0] iwIAddr,
    output logic [31:0] owIData,
    output logic        owIValid,
    input  logic        iwDReq,
    input  logic [31:0] iwDAddr,
    input  logic [3:0]  iwDWstrb,
    input  logic [31:0] iwDWData,
    output logic [31:0] owDRData,
    output logic        owDValid,
    output logic        owBusErr,
    output logic        owMemReq,
    output logic [31:0] owMemAddr,
    output logic [3:0]  owMemWstrb,
    output logic [31:0] owMemWData,
    input  logic [31:0] iwMemRData,
    input  logic        iwMemAck
);
    localparam int SW = $clog2(MAX_DATA_BURST + 1);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        ivalid_q, ivalid_d;
    logic        dvalid_q, dvalid_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        starved, grant_i, grant_d;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          buserr_q, buserr_d;
`endif
    // D wins ties until it has taken MAX_DATA_BURST grants in a row over a waiting I.
    assign starved = starve_q == SW'(MAX_DATA_BURST);
    assign grant_i = iwIReq && (!iwDReq || starved);
    assign grant_d = iwDReq && !grant_i;
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        idata_d   = idata_q;
        drdata_d  = drdata_q;
        ivalid_d  = 1'b0;
        dvalid_d  = 1'b0;
        starve_d  = iwIReq ? starve_q : '0;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
        buserr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d   = BUSY_I;
                    mem_req_d = 1'b1;
                    addr_d    = iwIAddr;
                    wstrb_d   = '0;
                    wdata_d   = '0;
                    starve_d  = '0;
                end else if (grant_d) begin
                    state_d   = BUSY_D;
                    mem_req_d = 1'b1;
                    addr_d    = iwDAddr;
                    wstrb_d   = iwDWstrb;
                    wdata_d   = iwDWData;
                    starve_d  = (iwIReq && !starved) ? starve_q + SW'(1) : starve_d;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
            BUSY_I, BUSY_D: begin
                if (iwMemAck) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    ivalid_d  = state_q == BUSY_I;
                    dvalid_d  = state_q == BUSY_D;
                    idata_d   = (state_q == BUSY_I) ? iwMemRData : idata_q;
                    drdata_d  = (state_q == BUSY_D && wstrb_q == 4'd0) ? iwMemRData : drdata_q;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    buserr_d  = 1'b1;
                    ivalid_d  = state_q == BUSY_I;
                    dvalid_d  = state_q == BUSY_D;
                    idata_d   = (state_q == BUSY_I) ? '0 : idata_q;
                    drdata_d  = (state_q == BUSY_D) ? '0 : drdata_q;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            idata_q   <= '0;
            drdata_q  <= '0;
            ivalid_q  <= 1'b0;
            dvalid_q  <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            idata_q   <= idata_d;
            drdata_q  <= drdata_d;
            ivalid_q  <= ivalid_d;
            dvalid_q  <= dvalid_d;
            starve_q  <= starve_d;
        end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            tmo_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            tmo_q    <= tmo_d;
            buserr_q <= buserr_d;
        end
    end
    assign owBusErr = buserr_q;
`else
    assign owBusErr = 1'b0;
`endif
    assign owMemReq   = mem_req_q;
    assign owMemAddr  = addr_q;
    assign owMemWstrb = wstrb_q;
    assign owMemWData = wdata_q;
    assign owIData    = idata_q;
    assign owDRData   = drdata_q;
    assign owIValid   = ivalid_q;
    assign owDValid   = dvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter_rv.sv
// tb_mem_port_arbiter_rv: directed self-checking bench for mem_port_arbiter_rv.
module tb_mem_port_arbiter_rv;
    logic        clk, rst_n;
    logic        i_req, d_req, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] i_data, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        i_valid, d_valid, bus_err, mem_req;
    int          n_tests = 0;
    int          n_fail = 0;
    mem_port_arbiter_rv dut (
        .iwClk(clk), .iwnRst(rst_n),
        .iwIReq(i_req), .iwIAddr(i_addr), .owIData(i_data), .owIValid(i_valid),
        .iwDReq(d_req), .iwDAddr(d_addr), .iwDWstrb(d_wstrb), .iwDWData(d_wdata),
        .owDRData(d_rdata), .owDValid(d_valid), .owBusErr(bus_err),
        .owMemReq(mem_req), .owMemAddr(mem_addr), .owMemWstrb(mem_wstrb),
        .owMemWData(mem_wdata), .iwMemRData(mem_rdata), .iwMemAck(mem_ack)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    initial begin
        logic [31:0] grants [10];
        int          n, busy, seen;
        logic        prev;
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wstrb = '0; d_wdata = '0; mem_rdata = '0;
        tick; tick;
        check("rst_memreq", mem_req, 1'b0);
        check("rst_ivalid", i_valid, 1'b0);
        check("rst_dvalid", d_valid, 1'b0);
        check("rst_buserr", bus_err, 1'b0);
        rst_n = 1'b1;
        tick;
        // fetch, ack two cycles after request
        i_req = 1'b1; i_addr = 32'h40;
        tick;
        check("fetch_req", mem_req, 1'b1);
        check("fetch_addr", mem_addr, 32'h40);
        check("fetch_wstrb", mem_wstrb, 4'd0);
        tick;
        check("fetch_hold", mem_req, 1'b1);
        check("fetch_early_valid", i_valid, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h13;
        tick;
        mem_ack = 1'b0; i_req = 1'b0;
        check("fetch_valid", i_valid, 1'b1);
        check("fetch_data", i_data, 32'h13);
        check("fetch_req_drop", mem_req, 1'b0);
        check("fetch_no_dvalid", d_valid, 1'b0);
        tick;
        check("fetch_valid_1cyc", i_valid, 1'b0);
        // data read
        d_req = 1'b1; d_addr = 32'h300; d_wstrb = 4'd0;
        tick;
        check("dread_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        mem_ack = 1'b0; d_req = 1'b0;
        check("dread_valid", d_valid, 1'b1);
        check("dread_data", d_rdata, 32'hDEADBEEF);
        check("dread_no_ivalid", i_valid, 1'b0);
        tick;
        // data write
        d_req = 1'b1; d_addr = 32'h100; d_wstrb = 4'b0011; d_wdata = 32'hABCD1234;
        tick;
        check("dwr_req", mem_req, 1'b1);
        check("dwr_addr", mem_addr, 32'h100);
        check("dwr_wstrb", mem_wstrb, 4'b0011);
        check("dwr_wdata", mem_wdata, 32'hABCD1234);
        tick;
        check("dwr_stable_wdata", mem_wdata, 32'hABCD1234);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick;
        mem_ack = 1'b0; d_req = 1'b0; d_wstrb = 4'd0;
        check("dwr_valid", d_valid, 1'b1);
        check("dwr_rdata_kept", d_rdata, 32'hDEADBEEF);
        tick;
        check("dwr_valid_1cyc", d_valid, 1'b0);
        // spurious ack in IDLE
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick;
        mem_ack = 1'b0;
        check("spur_idle_ivalid", i_valid, 1'b0);
        check("spur_idle_dvalid", d_valid, 1'b0);
        check("spur_idle_memreq", mem_req, 1'b0);
        check("spur_idle_idata", i_data, 32'h13);
        check("spur_idle_drdata", d_rdata, 32'hDEADBEEF);
        tick;
        // spurious ack in RESP
        i_req = 1'b1; i_addr = 32'h44;
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h22;
        tick;
        check("spur_resp_valid", i_valid, 1'b1);
        check("spur_resp_data", i_data, 32'h22);
        mem_rdata = 32'h99; i_req = 1'b0;
        tick;
        mem_ack = 1'b0;
        check("spur_resp_no_valid", i_valid, 1'b0);
        check("spur_resp_idata", i_data, 32'h22);
        check("spur_resp_memreq", mem_req, 1'b0);
        tick;
        check("spur_resp_idle", mem_req, 1'b0);
        // reset in the middle of a D write
        d_req = 1'b1; d_addr = 32'h200; d_wstrb = 4'hF; d_wdata = 32'h12345678;
        tick;
        check("rstmid_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_async_req", mem_req, 1'b0);
        check("rstmid_addr", mem_addr, 32'h0);
        check("rstmid_wstrb", mem_wstrb, 4'd0);
        check("rstmid_wdata", mem_wdata, 32'h0);
        check("rstmid_idata", i_data, 32'h0);
        check("rstmid_drdata", d_rdata, 32'h0);
        d_req = 1'b0; d_wstrb = 4'd0;
        tick;
        check("rstmid_dvalid", d_valid, 1'b0);
        rst_n = 1'b1;
        tick;
        check("rstmid_after_dvalid", d_valid, 1'b0);
        check("rstmid_after_req", mem_req, 1'b0);
        // I and D held together, zero-wait memory
        i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_addr = 32'h2000; mem_rdata = 32'hCAFE0000;
        n = 0; prev = 1'b0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick;
            mem_ack = mem_req;
            if (mem_req && !prev) begin
                grants[n] = mem_addr;
                n++;
            end
            prev = mem_req;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick;
        mem_ack = 1'b0;
        tick; tick;
        check("burst_grant_count", n, 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("burst_grant%0d", i), grants[i], (i % 5 == 4) ? 32'h1000 : 32'h2000);
        // ack withheld
        i_req = 1'b1; i_addr = 32'h80;
        busy = 0; seen = 0;
        tick;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 40 && mem_req; c++) begin
            busy++;
            tick;
        end
        check("tmo_busy_cycles", busy, 16);
        check("tmo_memreq", mem_req, 1'b0);
        check("tmo_ivalid", i_valid, 1'b1);
        check("tmo_buserr", bus_err, 1'b1);
        check("tmo_idata", i_data, 32'h0);
        i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555;
        tick;
        mem_ack = 1'b0;
        check("tmo_late_ivalid", i_valid, 1'b0);
        check("tmo_late_buserr", bus_err, 1'b0);
        check("tmo_late_idata", i_data, 32'h0);
        check("tmo_late_memreq", mem_req, 1'b0);
`else
        for (int c = 0; c < 20; c++) begin
            if (i_valid || bus_err || !mem_req) seen++;
            tick;
        end
        check("wait_no_event", seen, 0);
        check("wait_memreq", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h5555;
        tick;
        mem_ack = 1'b0; i_req = 1'b0;
        check("wait_ivalid", i_valid, 1'b1);
        check("wait_buserr", bus_err, 1'b0);
        check("wait_idata", i_data, 32'h5555);
`endif
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
